// File: rtl/control_fsm_pkg.sv
// Shared types for the accumulator-CPU instruction sequencer: opcodes, phases
// and the bundled control-strobe vector.
package control_fsm_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ, ADD, AND, XOR, LDA, STO, JMP
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR = 3'd0, INST_FETCH, INST_LOAD, IDLE,
    OP_ADDR, OP_FETCH, ALU_OP, STORE
  } state_t;

  // Field order matches the {mem_rd .. mem_wr} vector used by the datapath team.
  typedef struct packed {
    logic mem_rd;
    logic load_ir;
    logic halt;
    logic inc_pc;
    logic load_ac;
    logic load_pc;
    logic mem_wr;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic is_aluop(input opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

  function automatic state_t next_phase(input state_t s);
    return state_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational (phase, opcode, zero) -> control strobe decoder.
module control_decode
  import control_fsm_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    zero,
  output ctrl_t   ctrl
);

  logic aluop;

  always_comb begin
    // NOTE: every strobe gets a default first so no decode path infers a latch.
    ctrl  = CTRL_NONE;
    aluop = is_aluop(opcode);
    case (state)
      INST_ADDR: ctrl = CTRL_NONE;
      INST_FETCH: ctrl.mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        ctrl.mem_rd  = 1'b1;
        ctrl.load_ir = 1'b1;
      end
      OP_ADDR: begin
        ctrl.inc_pc = 1'b1;
        ctrl.halt   = (opcode == HLT);
      end
      OP_FETCH: ctrl.mem_rd = aluop;
      ALU_OP: begin
        ctrl.mem_rd  = aluop;
        ctrl.load_ac = aluop;
        ctrl.inc_pc  = (opcode == SKZ) && zero;
        ctrl.load_pc = (opcode == JMP);
      end
      STORE: begin
        ctrl.mem_rd  = aluop;
        ctrl.load_ac = aluop;
        ctrl.inc_pc  = (opcode == JMP);
        ctrl.load_pc = (opcode == JMP);
        ctrl.mem_wr  = (opcode == STO);
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Eight-phase instruction sequencer for the accumulator CPU.
// Define HALT_STOP_EN to freeze the sequencer in OP_ADDR after a HLT until reset.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic    clk,
  input  logic    rst_,
  input  opcode_t opcode,
  input  logic    zero,
  output state_t  state,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    halt,
  output logic    inc_pc,
  output logic    load_ac,
  output logic    load_pc,
  output logic    mem_wr
);

  state_t state_q, state_d;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (dec_ctrl)
  );

`ifdef HALT_STOP_EN
  logic halted_q, halted_d;

  always_comb begin
    state_d  = next_phase(state_q);
    halted_d = halted_q;
    if (halted_q || (state_q == OP_ADDR && opcode == HLT)) begin
      state_d  = OP_ADDR;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values together.
    if (rst_) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Held cycles keep halt up but must not keep bumping the PC.
  always_comb begin
    ctrl = dec_ctrl;
    if (halted_q) begin
      ctrl      = CTRL_NONE;
      ctrl.halt = 1'b1;
    end
  end
`else
  always_comb begin
    state_d = next_phase(state_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values together.
    if (rst_) state_q <= INST_ADDR;
    else      state_q <= state_d;
  end

  always_comb begin
    ctrl = dec_ctrl;
  end
`endif

  assign state   = state_q;
  assign mem_rd  = ctrl.mem_rd;
  assign load_ir = ctrl.load_ir;
  assign halt    = ctrl.halt;
  assign inc_pc  = ctrl.inc_pc;
  assign load_ac = ctrl.load_ac;
  assign load_pc = ctrl.load_pc;
  assign mem_wr  = ctrl.mem_wr;

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm: per-opcode phase walks plus an
// exhaustive (zero, opcode, phase) sweep against a small reference decode.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic    clk;
  logic    rst_;
  opcode_t opcode;
  logic    zero;
  state_t  state;
  logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [6:0] vec;

  int n_cmp;
  int n_fail;

  control_fsm dut (
    .clk     (clk),
    .rst_    (rst_),
    .opcode  (opcode),
    .zero    (zero),
    .state   (state),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .mem_wr  (mem_wr)
  );

  assign vec = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle well clear of it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
  endtask

  // Reference decode written straight from the phase table.
  function automatic logic [6:0] model_vec(input int p, input opcode_t op, input logic z);
    logic alu, jmp;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    jmp = (op == JMP);
    case (p)
      1:       model_vec = 7'b1000000;
      2, 3:    model_vec = 7'b1100000;
      4:       model_vec = {2'b00, op == HLT, 1'b1, 3'b000};
      5:       model_vec = {alu, 6'b000000};
      6:       model_vec = {alu, 2'b00, (op == SKZ) && z, alu, jmp, 1'b0};
      7:       model_vec = {alu, 2'b00, jmp, alu, jmp, op == STO};
      default: model_vec = 7'b0000000;
    endcase
  endfunction

  task automatic test_reset();
    logic [9:0] exp [6];
    opcode = ADD;
    zero   = 1'b0;
    rst_   = 1'b1;
    tick();
    rst_ = 1'b0;
    exp = '{{INST_ADDR, 7'b0000000}, {INST_FETCH, 7'b1000000},
            {ALU_OP, 7'b1000100},    {INST_ADDR, 7'b0000000},
            {INST_FETCH, 7'b1000000}, {INST_LOAD, 7'b1100000}};
    for (int i = 0; i < 6; i++) begin
      if (i == 1) tick();
      if (i == 2) repeat (5) tick();
      if (i == 3) begin rst_ = 1'b1; tick(); rst_ = 1'b0; end
      if (i >= 4) tick();
      #1;
      n_cmp++;
      if ({state, vec} !== exp[i]) begin
        n_fail++;
        $display("FAIL reset[%0d]: got state=%0d vec=%b, want state=%0d vec=%b",
                 i, state, vec, exp[i][9:7], exp[i][6:0]);
      end
    end
    do_reset();
  endtask

  task automatic test_alu_ops();
    logic [6:0] exp [8];
    opcode_t ops [5];
    logic    zs  [5];
    exp = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
            7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100};
    ops = '{ADD, AND, XOR, LDA, ADD};
    zs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k];
      zero   = zs[k];
      for (int p = 0; p < 9; p++) begin
        #1;
        n_cmp++;
        if ({state, vec} !== {3'(p % 8), exp[p % 8]}) begin
          n_fail++;
          $display("FAIL alu_%s z=%0b phase %0d: got state=%0d vec=%b, want vec=%b",
                   ops[k].name(), zs[k], p, state, vec, exp[p % 8]);
        end
        if (p < 8) tick();
      end
    end
  endtask

  task automatic test_hlt();
    logic [6:0] exp [8];
    exp = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
            7'b0011000, 7'b0000000, 7'b0000000, 7'b0000000};
    do_reset();
    opcode = HLT;
    zero   = 1'b0;
`ifdef HALT_STOP_EN
    for (int p = 0; p < 15; p++) begin
      #1;
      n_cmp++;
      if (p < 5) begin
        if ({state, vec} !== {3'(p), exp[p]}) begin
          n_fail++;
          $display("FAIL hlt phase %0d: got state=%0d vec=%b, want vec=%b", p, state, vec, exp[p]);
        end
      end else if ({state, vec} !== {OP_ADDR, 7'b0010000}) begin
        n_fail++;
        $display("FAIL hlt_hold %0d: got state=%0d vec=%b, want state=4 vec=0010000",
                 p - 4, state, vec);
      end
      tick();
    end
    opcode = ADD;
    do_reset();
    #1;
    n_cmp++;
    if ({state, vec} !== {INST_ADDR, 7'b0000000}) begin
      n_fail++;
      $display("FAIL hlt_release: got state=%0d vec=%b, want state=0 vec=0000000", state, vec);
    end
    opcode = HLT;
    do_reset();
`else
    for (int p = 0; p < 9; p++) begin
      #1;
      n_cmp++;
      if ({state, vec} !== {3'(p % 8), exp[p % 8]}) begin
        n_fail++;
        $display("FAIL hlt phase %0d: got state=%0d vec=%b, want vec=%b",
                 p, state, vec, exp[p % 8]);
      end
      if (p < 8) tick();
    end
`endif
  endtask

  task automatic test_skz();
    for (int z = 1; z >= 0; z--) begin
      opcode = SKZ;
      zero   = z[0];
      for (int p = 0; p < 9; p++) begin
        #1;
        n_cmp++;
        if (p == 6 && vec !== (z == 1 ? 7'b0001000 : 7'b0000000)) begin
          n_fail++;
          $display("FAIL skz z=%0d alu_op: got vec=%b", z, vec);
        end else if (p >= 7 && vec !== 7'b0000000 && p == 7) begin
          n_fail++;
          $display("FAIL skz z=%0d store: got vec=%b, want 0000000", z, vec);
        end else if (state !== state_t'(p % 8)) begin
          n_fail++;
          $display("FAIL skz z=%0d phase %0d: got state=%0d", z, p, state);
        end
        if (p < 8) tick();
      end
    end
  endtask

  task automatic test_jmp_sto();
    logic [6:0] exp [2][2];
    opcode_t ops [2];
    ops = '{JMP, STO};
    exp = '{'{7'b0000010, 7'b0001010}, '{7'b0000000, 7'b0000001}};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      zero   = 1'b1;
      repeat (6) tick();
      for (int j = 0; j < 2; j++) begin
        #1;
        n_cmp++;
        if ({state, vec} !== {3'(6 + j), exp[k][j]}) begin
          n_fail++;
          $display("FAIL %s phase %0d: got state=%0d vec=%b, want vec=%b",
                   ops[k].name(), 6 + j, state, vec, exp[k][j]);
        end
        tick();
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [6:0] want;
    for (int z = 0; z < 2; z++) begin
      for (int o = 0; o < 8; o++) begin
`ifdef HALT_STOP_EN
        if (o == 0) continue;
`endif
        opcode = opcode_t'(o);
        zero   = z[0];
        for (int p = 0; p < 9; p++) begin
          #1;
          want = model_vec(p % 8, opcode_t'(o), z[0]);
          n_cmp++;
          if ({state, vec} !== {3'(p % 8), want}) begin
            n_fail++;
            $display("FAIL sweep z=%0d op=%0d phase %0d: got state=%0d vec=%b, want vec=%b",
                     z, o, p, state, vec, want);
          end
          if (p < 8) tick();
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_   = 1'b1;
    opcode = ADD;
    zero   = 1'b0;
    test_reset();
    test_alu_ops();
    test_hlt();
    test_skz();
    test_jmp_sto();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Instruction-sequencing controller for the 8-bit accumulator CPU.
- An 8-phase state machine advances one phase per clock.
- Decodes the 3-bit opcode and the ALU zero flag into seven memory, PC, IR and accumulator control strobes.
- Sits between the instruction register/ALU and the datapath registers and memory.

Parameters:
- None. Widths are fixed by the shared package types.

Ports:
- clk  input  1  Rising-edge system clock.
- rst_  input  1  Synchronous, active-high reset. Port name is kept from the codebase; polarity is active-high regardless of the suffix.
- opcode  input  3 (opcode_t)  Current instruction opcode.
- zero  input  1  Accumulator-is-zero flag from the ALU.
- state  output  3 (state_t)  Current phase.
- mem_rd  output  1  Memory read enable.
- load_ir  output  1  Load instruction register.
- halt  output  1  Halt indication.
- inc_pc  output  1  Increment program counter.
- load_ac  output  1  Load accumulator.
- load_pc  output  1  Load program counter.
- mem_wr  output  1  Memory write enable.

Behaviour:
- Phase register:
  - Order: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7).
  - STORE wraps to INST_ADDR.
  - Advances unconditionally every rising clk edge; there are no handshakes.
- Reset:
  - rst_=1 at a rising edge loads INST_ADDR, overriding the advance, including mid-instruction.
  - While in INST_ADDR all outputs are 0.
- Outputs are purely combinational from (state, opcode, zero); no extra latency.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Output decode per phase (any output not listed is 0):
  - INST_ADDR: all 0.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).
- Each output is driven in every branch of the decode so no latches are inferred. Unknown state decodes to all-0.
- Boundaries:
  - SKZ with zero=0 produces no strobe in ALU_OP.
  - zero is ignored for all opcodes except SKZ.
  - halt is a single-phase strobe; the sequencer continues unless HALT_STOP_EN is defined.

Optional Feature:
- Macro HALT_STOP_EN.
- Defined:
  - Once in OP_ADDR with opcode==HLT, the phase register holds OP_ADDR on every subsequent edge and halt stays 1.
  - Only rst_ releases the hold, returning to INST_ADDR.
  - inc_pc is 1 in the OP_ADDR phase where HLT is first decoded and 0 on every held cycle after it.
- Undefined: halt is asserted for the OP_ADDR phase only and sequencing continues normally.

Decomposition:
- Package typedefs holds:
  - opcode_t: 3-bit enum HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP.
  - state_t: 3-bit enum INST_ADDR=0, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- One natural sub-module, control_decode: the combinational (state, opcode, zero) -> 7-strobe decoder.
- The top holds the phase register and the HALT_STOP_EN logic.

Test Plan:
Vectors are {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, listed phase 0..7.
- Reset: rst_=1 for 1 clk mid-ALU_OP -> next state INST_ADDR, vector 0000000. Then phases advance 1 per clk.
- ADD, zero=0 -> 0000000, 1000000, 1100000, 1100000, 0001000, 1000000, 1000100, 1000100. LDA, AND and XOR give identical vectors.
- HLT -> OP_ADDR 0011000; OP_FETCH/ALU_OP/STORE 0000000. With HALT_STOP_EN: state stays OP_ADDR, halt=1, inc_pc=0 for the next 10 clks.
- SKZ -> zero=1: ALU_OP 0001000. zero=0: ALU_OP 0000000. STORE 0000000 in both cases.
- JMP -> ALU_OP 0000010, STORE 0001010. STO -> ALU_OP 0000000, STORE 0000001.
- Exhaustive: all 16 (zero, opcode) combos × 8 phases are compared against the decode above. Wrap STORE -> INST_ADDR is checked every pass.
